// File: rtl/signed_div_pow2_pipelined.sv
// Pipelined signed a / 2^s with per-beat floor or truncate-toward-zero rounding.
// Optional feature macro: SIGNED_DIV_POW2_REM_EN adds the pipelined remainder port out_rem.
module signed_div_pow2_pipelined #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [$clog2(W):0] in_shift,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data
`ifdef SIGNED_DIV_POW2_REM_EN
  ,
  output logic [W-1:0]       out_rem
`endif
);

  localparam int SW = $clog2(W) + 1;

  logic          w_en;
  logic [SW-1:0] w_s0;
  logic [W:0]    w_a0;
  logic [W:0]    w_bias0;
  logic [W:0]    w_sh [1:SW];

  logic          r_v   [0:SW];
  logic [W:0]    r_val [0:SW];
  logic [SW-1:0] r_s   [0:SW-1];
`ifdef SIGNED_DIV_POW2_REM_EN
  logic [W-1:0]  r_a   [0:SW-1];
  logic [W-1:0]  r_rem;
`endif

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Truncate mode biases negative dividends by 2^s-1 so the floor shift rounds toward zero.
  assign w_s0    = (in_shift > SW'(W)) ? SW'(W) : in_shift;
  assign w_a0    = {in_data[W-1], in_data};
  assign w_bias0 = (in_mode && in_data[W-1]) ? (((W+1)'(1) << w_s0) - (W+1)'(1)) : '0;

  genvar gi;
  for (gi = 1; gi <= SW; gi++) begin : g_stage
    localparam int K = 1 << (gi - 1);
    if (K > W) begin : g_all
      assign w_sh[gi] = r_s[gi-1][gi-1] ? {(W+1){r_val[gi-1][W]}} : r_val[gi-1];
    end else begin : g_cat
      assign w_sh[gi] = r_s[gi-1][gi-1] ? {{K{r_val[gi-1][W]}}, r_val[gi-1][W:K]}
                                        : r_val[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= SW; i++) begin
        r_v[i]   <= 1'b0;
        r_val[i] <= '0;
      end
      for (int i = 0; i < SW; i++) begin
        r_s[i] <= '0;
`ifdef SIGNED_DIV_POW2_REM_EN
        r_a[i] <= '0;
`endif
      end
`ifdef SIGNED_DIV_POW2_REM_EN
      r_rem <= '0;
`endif
    end else if (w_en) begin
      r_v[0]   <= in_valid;
      r_val[0] <= w_a0 + w_bias0;
      r_s[0]   <= w_s0;
      for (int i = 1; i <= SW; i++) begin
        r_v[i]   <= r_v[i-1];
        r_val[i] <= w_sh[i];
      end
      for (int i = 1; i < SW; i++) begin
        r_s[i] <= r_s[i-1];
      end
`ifdef SIGNED_DIV_POW2_REM_EN
      r_a[0] <= in_data;
      for (int i = 1; i < SW; i++) begin
        r_a[i] <= r_a[i-1];
      end
      // Low W bits of a - q*2^s; the W+1-bit product wraps harmlessly.
      r_rem <= r_a[SW-1] - W'(w_sh[SW] << r_s[SW-1]);
`endif
    end
  end

  assign out_valid = r_v[SW];
  assign out_data  = r_val[SW][W-1:0];
`ifdef SIGNED_DIV_POW2_REM_EN
  assign out_rem   = r_rem;
`endif

endmodule

// File: tb/tb_signed_div_pow2_pipelined.sv
// Bench for signed_div_pow2_pipelined (W=8): directed vectors plus random stream against an integer model.
module tb_signed_div_pow2_pipelined;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_shift = '0;
  logic       in_mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
`ifdef SIGNED_DIV_POW2_REM_EN
  logic [7:0] out_rem;
`endif

  signed_div_pow2_pipelined #(.W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_shift(in_shift),
    .in_mode(in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef SIGNED_DIV_POW2_REM_EN
    ,
    .out_rem(out_rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    longint     enc;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  longint     en_count = 0;
  logic [7:0] drv_q = '0;
  logic [7:0] drv_r = '0;
  logic       prev_stall = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_q = '0;
  logic [7:0] prev_r = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Quotient/remainder from plain integer arithmetic: >>> for floor, C-style / for truncate.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [3:0] s, input logic m);
    int ai, sc, q, r;
    ai = $signed(a);
    sc = (s > 4'd8) ? 8 : int'(s);
    if (!m) q = ai >>> sc;
    else    q = ai / (1 << sc);
    r = ai - q * (1 << sc);
    return {q[7:0], r[7:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall && !prev_rst) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_q);
`ifdef SIGNED_DIV_POW2_REM_EN
        chk("hold_rem", out_rem, prev_r);
`endif
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat got=%0h expected=none at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("q", out_data, e.q);
`ifdef SIGNED_DIV_POW2_REM_EN
          chk("rem", out_rem, e.r);
`endif
          chk("latency", en_count - e.enc, 5);
        end
      end
      if (in_valid && in_ready) sb.push_back('{drv_q, drv_r, en_count});
      prev_stall = out_valid && !out_ready;
      prev_q     = out_data;
`ifdef SIGNED_DIV_POW2_REM_EN
      prev_r     = out_rem;
`endif
      if (!out_valid || out_ready) en_count++;
      prev_rst = 1'b0;
    end
  end

  task automatic send(input logic [7:0] a, input logic [3:0] s, input logic m,
                      input logic [7:0] eq, input logic [7:0] er);
    int t = 0;
    in_valid = 1'b1;
    in_data  = a;
    in_shift = s;
    in_mode  = m;
    drv_q    = eq;
    drv_r    = er;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 1000);
    if (!in_ready) chk("send_timeout", t, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_model(input logic [7:0] a, input logic [3:0] s, input logic m);
    logic [15:0] mr;
    mr = model(a, s, m);
    send(a, s, m, mr[15:8], mr[7:0]);
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // {a, s, mode, q, rem}
  logic [28:0] vtab [16] = '{
    {8'hF9, 4'd1,  1'b0, 8'hFC, 8'h01},
    {8'hF9, 4'd1,  1'b1, 8'hFD, 8'hFF},
    {8'h80, 4'd7,  1'b0, 8'hFF, 8'h00},
    {8'h80, 4'd7,  1'b1, 8'hFF, 8'h00},
    {8'h80, 4'd8,  1'b0, 8'hFF, 8'h80},
    {8'h80, 4'd8,  1'b1, 8'h00, 8'h80},
    {8'h80, 4'd15, 1'b0, 8'hFF, 8'h80},
    {8'h80, 4'd15, 1'b1, 8'h00, 8'h80},
    {8'h64, 4'd3,  1'b0, 8'h0C, 8'h04},
    {8'h64, 4'd3,  1'b1, 8'h0C, 8'h04},
    {8'h64, 4'd0,  1'b0, 8'h64, 8'h00},
    {8'h64, 4'd0,  1'b1, 8'h64, 8'h00},
    {8'h7F, 4'd8,  1'b1, 8'h00, 8'h7F},
    {8'h7F, 4'd8,  1'b0, 8'h00, 8'h7F},
    {8'hFF, 4'd4,  1'b1, 8'h00, 8'hFF},
    {8'hFF, 4'd4,  1'b0, 8'hFF, 8'h0F}
  };

  initial begin
    logic [28:0] v;
    logic [15:0] mr;
    logic        acc;
    int          sent;
    int          cyc;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_ready", in_ready, 1);
`ifdef SIGNED_DIV_POW2_REM_EN
    chk("reset_rem", out_rem, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      v  = vtab[i];
      mr = model(v[28:21], v[20:17], v[16]);
      chk("model_q", mr[15:8], v[15:8]);
      chk("model_rem", mr[7:0], v[7:0]);
      send(v[28:21], v[20:17], v[16], v[15:8], v[7:0]);
    end
    drain();

    for (int i = 0; i < 16; i++)
      send_model(8'(i * 37 - 100), 4'(i % 10), i[0]);
    drain();

    fork
      begin
        for (int i = 0; i < 12; i++)
          send_model(8'(i * 23 + 130), 4'(i % 9), i[1]);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++)
      send_model(8'(i * 50 - 60), 4'(i + 1), i[0]);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
`ifdef SIGNED_DIV_POW2_REM_EN
    chk("midrst_rem", out_rem, 0);
`endif
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    send(8'hF9, 4'd1, 1'b1, 8'hFD, 8'hFF);
    drain();

    acc  = 1'b0;
    sent = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        in_data  = 8'($urandom);
        in_shift = 4'($urandom_range(0, 15));
        in_mode  = 1'($urandom);
        mr       = model(in_data, in_shift, in_mode);
        drv_q    = mr[15:8];
        drv_r    = mr[7:0];
      end
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("random_sent", sent, 10000);
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
